mac16_accum: RTL and testbench



---
 rtl/mac_pkg.sv | 11 +
 rtl/array_mult16.sv | 22 ++
 rtl/mac16_accum.sv | 148 ++++++++++++++
 tb/tb_mac16_accum.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared constants for the mac16_accum multiply-accumulate slice.
//   ACC_W_DEF : default accumulator / result width (must be >= PROD_W)
//   CNT_W_DEF : default beat-counter width
//   PROD_W    : width of the 16x16 unsigned product
package mac_pkg;

  localparam int ACC_W_DEF = 40;
  localparam int CNT_W_DEF = 8;
  localparam int PROD_W    = 32;

endpackage

// File: rtl/array_mult16.sv
// Combinational 16x16 unsigned array multiplier.
// Ports:
//   a : 16-bit unsigned multiplicand
//   b : 16-bit unsigned multiplier
//   p : 32-bit unsigned product a*b
module array_mult16
  import mac_pkg::*;
(
  input  logic [15:0]       a,
  input  logic [15:0]       b,
  output logic [PROD_W-1:0] p
);

  // Sum of shifted partial products, one row per multiplier bit.
  always_comb begin
    p = {PROD_W{1'b0}};
    for (int i = 0; i < 16; i++) begin
      p = p + ({PROD_W{b[i]}} & (PROD_W'(a) << i));
    end
  end

endmodule

// File: rtl/mac16_accum.sv
// Pipelined multiply-accumulate: registers operands (S1), registers the
// 32-bit product (S2), and accumulates products per in_last-delimited group
// (S3), presenting each group sum on a valid/ready output.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   in_valid/in_ready      : operand beat handshake
//   in_a, in_b, in_last    : unsigned operands, group-closing flag
//   acc_clr                : synchronous flush of accumulation state
//   out_valid/out_ready    : result handshake
//   out_acc, out_count     : group sum and saturating beat count
//   out_ovf                : group sum exceeded ACC_W bits
module mac16_accum
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic             in_last,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              stall_s;
  logic              accept_s;
  logic              load_s;
  logic [PROD_W-1:0] prod_s;
  logic [ACC_W:0]    sum_s;
  logic [CNT_W-1:0]  cnt_next_s;
  logic              ovf_next_s;

  logic [15:0]       a_r;
  logic [15:0]       b_r;
  logic              last1_r;
  logic              v1_r;
  logic [PROD_W-1:0] prod_r;
  logic              last2_r;
  logic              v2_r;
  logic [ACC_W-1:0]  acc_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              ovf_r;
  logic              out_valid_r;
  logic [ACC_W-1:0]  out_acc_r;
  logic [CNT_W-1:0]  out_count_r;
  logic              out_ovf_r;

  // A held result that nobody takes freezes the whole pipe; gating with
  // rst_n keeps in_ready low while reset is asserted.
  assign stall_s  = out_valid_r & ~out_ready;
  assign in_ready = rst_n & ~stall_s & ~acc_clr;
  assign accept_s = in_valid & in_ready;
  // A closing beat in S2 publishes its group; acc_clr kills it first.
  assign load_s   = v2_r & last2_r & ~stall_s & ~acc_clr;

  array_mult16 u_mult (
    .a (a_r),
    .b (b_r),
    .p (prod_s)
  );

  // S3 arithmetic: widened add exposes the carry out of ACC_W.
  always_comb begin
    sum_s      = (ACC_W+1)'(acc_r) + (ACC_W+1)'(prod_r);
    ovf_next_s = ovf_r | sum_s[ACC_W];
    if (cnt_r == CNT_MAX) begin
      cnt_next_s = cnt_r;
    end else begin
      cnt_next_s = cnt_r + CNT_W'(1);
    end
  end

  // S1/S2 pipeline registers and the running accumulator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r     <= 16'd0;
      b_r     <= 16'd0;
      last1_r <= 1'b0;
      v1_r    <= 1'b0;
      prod_r  <= {PROD_W{1'b0}};
      last2_r <= 1'b0;
      v2_r    <= 1'b0;
      acc_r   <= {ACC_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      ovf_r   <= 1'b0;
    end else if (acc_clr) begin
      v1_r  <= 1'b0;
      v2_r  <= 1'b0;
      acc_r <= {ACC_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
      ovf_r <= 1'b0;
    end else if (!stall_s) begin
      v1_r <= accept_s;
      if (accept_s) begin
        a_r     <= in_a;
        b_r     <= in_b;
        last1_r <= in_last;
      end
      v2_r    <= v1_r;
      last2_r <= last1_r;
      prod_r  <= prod_s;
      if (v2_r) begin
        if (last2_r) begin
          acc_r <= {ACC_W{1'b0}};
          cnt_r <= {CNT_W{1'b0}};
          ovf_r <= 1'b0;
        end else begin
          acc_r <= sum_s[ACC_W-1:0];
          cnt_r <= cnt_next_s;
          ovf_r <= ovf_next_s;
        end
      end
    end
  end

  // Result register: a new load wins over the consume of the old result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_acc_r   <= {ACC_W{1'b0}};
      out_count_r <= {CNT_W{1'b0}};
      out_ovf_r   <= 1'b0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_acc_r   <= sum_s[ACC_W-1:0];
      out_count_r <= cnt_next_s;
      out_ovf_r   <= ovf_next_s;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_valid = out_valid_r;
  assign out_acc   = out_acc_r;
  assign out_count = out_count_r;
  assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_mac16_accum.sv
// Self-checking bench for mac16_accum: a default 40-bit instance and a
// 32-bit instance share inputs; expected group results come from plain
// 64-bit arithmetic over each group's products.
module tb_mac16_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_last;
  logic        acc_clr;
  logic        out_ready;

  logic        in_ready, out_valid, out_ovf;
  logic [39:0] out_acc;
  logic [7:0]  out_count;
  logic        in_ready32, out_valid32, out_ovf32;
  logic [31:0] out_acc32;
  logic [7:0]  out_count32;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] q_sum[$];
  int          q_cnt[$];
  bit          coll_done;

  always #5 clk = ~clk;

  mac16_accum dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_count(out_count), .out_ovf(out_ovf)
  );

  mac16_accum #(.ACC_W(32), .CNT_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .acc_clr(acc_clr),
    .out_valid(out_valid32), .out_ready(out_ready), .out_acc(out_acc32),
    .out_count(out_count32), .out_ovf(out_ovf32)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Offer one beat (entered at posedge+1), return at posedge+1 after accept.
  task automatic send_beat(input logic [15:0] a, input logic [15:0] b, input logic last);
    int waited = 0;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL beat_accept: in_ready=%b, required 1 within 200 cycles", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Compare one presented result of both instances against a true group sum.
  task automatic check_result(input logic [63:0] sum, input int nbeats, input string name);
    logic [7:0] ec;
    ec = (nbeats > 255) ? 8'd255 : 8'(nbeats);
    n_cmp += 7;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL %s valid: got %b want 1", name, out_valid); end
    if (out_acc !== sum[39:0]) begin n_err++; $display("FAIL %s acc40: got %h want %h", name, out_acc, sum[39:0]); end
    if (out_count !== ec) begin n_err++; $display("FAIL %s count: got %0d want %0d", name, out_count, ec); end
    if (out_ovf !== (sum[63:40] != 24'd0)) begin n_err++; $display("FAIL %s ovf40: got %b want %b", name, out_ovf, sum[63:40] != 24'd0); end
    if (out_acc32 !== sum[31:0]) begin n_err++; $display("FAIL %s acc32: got %h want %h", name, out_acc32, sum[31:0]); end
    if (out_ovf32 !== (sum[63:32] != 32'd0)) begin n_err++; $display("FAIL %s ovf32: got %b want %b", name, out_ovf32, sum[63:32] != 32'd0); end
    if (out_count32 !== ec) begin n_err++; $display("FAIL %s count32: got %0d want %0d", name, out_count32, ec); end
  endtask

  // Wait (bounded) for the next result with out_ready high; ends at posedge+1.
  task automatic wait_out(input logic [63:0] sum, input int nbeats, input string name);
    int waited = 0;
    @(negedge clk);
    while (!out_valid && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    check_result(sum, nbeats, name);
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_a = 16'd0; in_b = 16'd0;
    in_last = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp += 6;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    if (out_acc !== 40'd0) begin n_err++; $display("FAIL reset_acc: got %h want 0", out_acc); end
    if (out_count !== 8'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", out_count); end
    if (out_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", out_ovf); end
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", in_ready); end
    if (in_ready32 !== 1'b0) begin n_err++; $display("FAIL reset_ready32: got %b want 0", in_ready32); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp += 2;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_ready: got %b want 1", in_ready); end
    if (in_ready32 !== 1'b1) begin n_err++; $display("FAIL release_ready32: got %b want 1", in_ready32); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_beat;
    send_beat(16'd3, 16'd5, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k < 2) begin
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_latency: out_valid=%b after %0d edges, want 0", out_valid, k + 1); end
      end else begin
        check_result(64'd15, 1, "single");
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_max_operands;
    for (int i = 0; i < 4; i++) begin
      in_a = 16'hFFFF; in_b = 16'hFFFF; in_last = (i == 3); in_valid = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL max_ready: beat %0d in_ready=%b want 1", i, in_ready); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    wait_out(64'd4 * 64'hFFFE0001, 4, "max4");
  endtask

  task automatic test_overflow;
    send_beat(16'hFFFF, 16'hFFFF, 1'b0);
    send_beat(16'hFFFF, 16'hFFFF, 1'b1);
    wait_out(64'd2 * 64'hFFFE0001, 2, "ovf_group");
    send_beat(16'd1, 16'd1, 1'b1);
    wait_out(64'd1, 1, "after_ovf");
  endtask

  task automatic test_backpressure;
    int waited = 0;
    out_ready = 1'b0;
    send_beat(16'd2, 16'd2, 1'b1);
    send_beat(16'd3, 16'd3, 1'b1);
    @(negedge clk);
    while (!out_valid && waited < 20) begin waited++; @(negedge clk); end
    for (int k = 0; k < 10; k++) begin
      n_cmp += 3;
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid: got %b want 1", out_valid); end
      if (out_acc !== 40'd4) begin n_err++; $display("FAIL bp_hold_acc: got %0d want 4", out_acc); end
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready: got %b want 0", in_ready); end
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check_result(64'd4, 1, "bp_first");
    @(negedge clk);
    check_result(64'd9, 1, "bp_second");
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: out_valid=%b want 0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_acc_clr;
    out_ready = 1'b1;
    send_beat(16'd10, 16'd10, 1'b0);
    send_beat(16'd20, 16'd20, 1'b0);
    acc_clr = 1'b1; in_valid = 1'b1; in_a = 16'd99; in_b = 16'd99; in_last = 1'b1;
    @(negedge clk);
    n_cmp += 2;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL clr_ready: got %b want 0", in_ready); end
    if (in_ready32 !== 1'b0) begin n_err++; $display("FAIL clr_ready32: got %b want 0", in_ready32); end
    @(posedge clk); #1;
    acc_clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    send_beat(16'd7, 16'd7, 1'b1);
    wait_out(64'd49, 1, "after_clr");
  endtask

  task automatic test_reset_mid_group;
    int waited = 0;
    out_ready = 1'b0;
    send_beat(16'd4, 16'd4, 1'b1);
    send_beat(16'd5, 16'd5, 1'b0);
    @(negedge clk);
    while (!out_valid && waited < 20) begin waited++; @(negedge clk); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_mid_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    n_cmp += 4;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
    if (out_acc !== 40'd0) begin n_err++; $display("FAIL rst_mid_acc: got %h want 0", out_acc); end
    if (out_count !== 8'd0) begin n_err++; $display("FAIL rst_mid_count: got %0d want 0", out_count); end
    if (out_ovf !== 1'b0) begin n_err++; $display("FAIL rst_mid_ovf: got %b want 0", out_ovf); end
    rst_n = 1'b1; out_ready = 1'b1;
    send_beat(16'd2, 16'd3, 1'b1);
    wait_out(64'd6, 1, "after_rst");
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 300; i++) send_beat(16'd1, 16'd1, i == 299);
    wait_out(64'd300, 300, "saturate");
  endtask

  task automatic test_random;
    localparam int NG = 25;
    int got = 0;
    coll_done = 1'b0;
    fork
      begin
        for (int g = 0; g < NG; g++) begin
          int len;
          logic [63:0] sum;
          len = $urandom_range(1, 6);
          sum = 64'd0;
          for (int i = 0; i < len; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom); b = 16'($urandom);
            sum = sum + 64'(a) * 64'(b);
            if (i == len - 1) begin q_sum.push_back(sum); q_cnt.push_back(len); end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_beat(a, b, i == len - 1);
          end
        end
      end
      begin
        while (!coll_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        int cyc = 0;
        while (got < NG && cyc < 5000) begin
          @(negedge clk);
          cyc++;
          if (out_valid && out_ready) begin
            n_cmp++;
            if (q_sum.size() == 0) begin
              n_err++;
              $display("FAIL rand_extra: result %h with no group pending", out_acc);
            end else begin
              check_result(q_sum.pop_front(), q_cnt.pop_front(), "rand");
            end
            got++;
          end
        end
        n_cmp++;
        if (got != NG) begin n_err++; $display("FAIL rand_timeout: got %0d results want %0d", got, NG); end
        coll_done = 1'b1;
      end
    join
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_max_operands();
    test_overflow();
    test_backpressure();
    test_acc_clr();
    test_reset_mid_group();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
